// File: rtl/divider_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle divider among NUM_REQ clients.
// Optional macro DIV_ZERO_BYPASS_EN answers zero-divisor requests without running the divider.
module divider_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic [1:0]                 rsp_error,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_done,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder
);

  // state  | meaning
  // IDLE   | arbitrate, accept one operand pair
  // LAUNCH | one-cycle div_start pulse, clear timeout counter
  // WAIT   | wait for div_done or timeout
  // RESP   | present result to granted requester until rsp_ready

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        ptr;
  logic [GW-1:0]        sel;
  logic [GW-1:0]        idx_g;
  logic                 any_valid;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;
  logic                 rsp_ack;
  logic [CW-1:0]        cnt;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    idx_g     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_g = GW'((int'(ptr) + i) % NUM_REQ);
      if (!any_valid && req_valid[idx_g]) begin
        any_valid = 1'b1;
        sel       = idx_g;
      end
    end
  end

  always_comb begin
    sel_onehot   = '0;
    grant_onehot = '0;
    sel_a        = '0;
    sel_b        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == sel) begin
        sel_onehot[i] = 1'b1;
        sel_a         = req_dividend[i*WIDTH +: WIDTH];
        sel_b         = req_divisor[i*WIDTH +: WIDTH];
      end
      if (GW'(i) == grant_id) grant_onehot[i] = 1'b1;
    end
  end

  assign rsp_ack = |(rsp_ready & grant_onehot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    div_start = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by rst_n so req_ready reads 0 while reset is held.
        if (any_valid && rst_n) begin
          req_ready = sel_onehot;
`ifdef DIV_ZERO_BYPASS_EN
          state_nxt = (sel_b == '0) ? RESP : LAUNCH;
`else
          state_nxt = LAUNCH;
`endif
        end
      end
      LAUNCH: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_done || (cnt == CNT_LAST)) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = grant_onehot;
        if (rsp_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      grant_id      <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_error     <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            div_dividend <= sel_a;
            div_divisor  <= sel_b;
            grant_id     <= sel;
            rsp_error    <= 2'b00;
`ifdef DIV_ZERO_BYPASS_EN
            if (sel_b == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_a;
              rsp_error     <= 2'b01;
            end
`endif
          end
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          // done wins over a timeout landing in the same cycle
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_error     <= {1'b0, (div_divisor == '0)};
          end else if (cnt == CNT_LAST) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_error     <= 2'b10;
          end
        end
        RESP: begin
          if (rsp_ack) ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
